// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolution controller and its gshare predictor.
// Holds the FSM state encoding, the 2-bit counter values and the counter update rule.
package bp_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REMEDY = 1'b1
    } state_t;

    localparam logic [1:0] CNT_SNT   = 2'b00;
    localparam logic [1:0] CNT_WNT   = 2'b01;
    localparam logic [1:0] CNT_WT    = 2'b10;
    localparam logic [1:0] CNT_ST    = 2'b11;
    localparam logic [1:0] CNT_RESET = CNT_WNT;

    // Saturating 2-bit counter step: strong states hold at the rails.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] result;
        result = cnt;
        if (taken && cnt != CNT_ST) begin
            result = cnt + 2'd1;
        end else if (!taken && cnt != CNT_SNT) begin
            result = cnt - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table for the gshare predictor: 2**IDX_BITS 2-bit counters,
// one combinational read port for fetch and one synchronous update port from EX.
module bp_pht
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_taken,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int ENTRIES = 2 ** IDX_BITS;

    logic [1:0] counters [ENTRIES];

    // No write-to-read bypass: fetch sees the counter value from before this cycle's update.
    assign rd_taken = counters[rd_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= CNT_RESET;
            end
        end else if (wr_en) begin
            counters[wr_idx] <= cnt_next(counters[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves branches/jumps coming out of EX: drives BTB updates, the one-cycle
// redirect (remedy) and IF/ID flush, and owns the gshare GHR plus PHT.
module branch_resolve_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 10,
    parameter int GHR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] fetch_pc,
    output logic        gpre,
    input  logic        res_valid,
    input  logic        res_is_branch,
    input  logic        res_is_jump,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_choice,
    input  logic [31:0] res_pred_npc,
    output logic        btb_update_en,
    output logic [31:0] btb_old_pc,
    output logic [31:0] btb_check_addr,
    output logic        btb_is_branch,
    output logic        btb_is_jump,
    output logic        btb_update_choice,
    output logic        btb_old_choice,
    output logic        btb_remedy,
    output logic        flush
);

    state_t              state;
    state_t              state_next;
    logic [GHR_BITS-1:0] ghr;

    logic                eff_branch;
    logic                eff_taken;
    logic                accept;
    logic                mispred;
    logic                pht_wr_en;
    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic                unused_pc_bits;

    // A jump wins over a simultaneous branch flag and is always taken.
    assign eff_branch = res_is_branch & ~res_is_jump;
    assign eff_taken  = res_is_jump | res_taken;

    // Wrong-path resolutions arriving during REMEDY are dropped by the state check.
    assign accept = res_valid & ~stall & (res_is_branch | res_is_jump) & (state == IDLE);

    assign mispred = (eff_taken != res_pred_choice)
                   | ( eff_taken & (res_pred_npc != res_target))
                   | (~eff_taken & (res_pred_npc != (res_pc + 32'd4)));

    assign rd_idx    = fetch_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
    assign wr_idx    = res_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
    assign pht_wr_en = accept & eff_branch;

    assign unused_pc_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0]};

    bp_pht #(
        .IDX_BITS (IDX_BITS)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_taken (gpre),
        .wr_en    (pht_wr_en),
        .wr_idx   (wr_idx),
        .wr_taken (eff_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // REMEDY lasts exactly one cycle regardless of stall.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && mispred) state_next = REMEDY;
            REMEDY:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign btb_remedy = (state == REMEDY);
    assign flush      = (state == REMEDY);

    // BTB-facing fields load only on accept and otherwise keep the last resolution.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_update_en     <= 1'b0;
            btb_old_pc        <= 32'd0;
            btb_check_addr    <= 32'd0;
            btb_is_branch     <= 1'b0;
            btb_is_jump       <= 1'b0;
            btb_update_choice <= 1'b0;
            btb_old_choice    <= 1'b0;
        end else begin
            btb_update_en <= accept & eff_taken;
            if (accept) begin
                btb_old_pc        <= res_pc;
                btb_check_addr    <= res_target;
                btb_is_branch     <= eff_branch;
                btb_is_jump       <= res_is_jump;
                btb_update_choice <= eff_taken;
                btb_old_choice    <= res_pred_choice;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (pht_wr_en) begin
            ghr <= {ghr[GHR_BITS-2:0], eff_taken};
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl: reset, redirects, PHT
// training/saturation, REMEDY blocking, stall and reset-during-REMEDY.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] fetch_pc;
    logic        gpre;
    logic        res_valid;
    logic        res_is_branch;
    logic        res_is_jump;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_choice;
    logic [31:0] res_pred_npc;
    logic        btb_update_en;
    logic [31:0] btb_old_pc;
    logic [31:0] btb_check_addr;
    logic        btb_is_branch;
    logic        btb_is_jump;
    logic        btb_update_choice;
    logic        btb_old_choice;
    logic        btb_remedy;
    logic        flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(
        .IDX_BITS (10),
        .GHR_BITS (10)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .fetch_pc          (fetch_pc),
        .gpre              (gpre),
        .res_valid         (res_valid),
        .res_is_branch     (res_is_branch),
        .res_is_jump       (res_is_jump),
        .res_pc            (res_pc),
        .res_taken         (res_taken),
        .res_target        (res_target),
        .res_pred_choice   (res_pred_choice),
        .res_pred_npc      (res_pred_npc),
        .btb_update_en     (btb_update_en),
        .btb_old_pc        (btb_old_pc),
        .btb_check_addr    (btb_check_addr),
        .btb_is_branch     (btb_is_branch),
        .btb_is_jump       (btb_is_jump),
        .btb_update_choice (btb_update_choice),
        .btb_old_choice    (btb_old_choice),
        .btb_remedy        (btb_remedy),
        .flush             (flush)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_pulses(input string tag, input logic upd, input logic rem, input logic fl);
        check({tag, ".update_en"}, {31'd0, btb_update_en}, {31'd0, upd});
        check({tag, ".remedy"},    {31'd0, btb_remedy},    {31'd0, rem});
        check({tag, ".flush"},     {31'd0, flush},         {31'd0, fl});
    endtask

    task automatic check_gpre(input string tag, input logic [31:0] pc, input logic exp);
        fetch_pc = pc;
        #1;
        check(tag, {31'd0, gpre}, {31'd0, exp});
    endtask

    task automatic clear_res();
        res_valid       = 1'b0;
        res_is_branch   = 1'b0;
        res_is_jump     = 1'b0;
        res_pc          = 32'd0;
        res_taken       = 1'b0;
        res_target      = 32'd0;
        res_pred_choice = 1'b0;
        res_pred_npc    = 32'd0;
    endtask

    task automatic set_res(input logic br, input logic jmp, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic ch, input logic [31:0] npc);
        res_valid       = 1'b1;
        res_is_branch   = br;
        res_is_jump     = jmp;
        res_pc          = pc;
        res_taken       = tk;
        res_target      = tgt;
        res_pred_choice = ch;
        res_pred_npc    = npc;
    endtask

    // Presents one resolution for a single cycle; returns at the negedge of cycle N+1.
    task automatic apply_res(input logic br, input logic jmp, input logic [31:0] pc, input logic tk,
                             input logic [31:0] tgt, input logic ch, input logic [31:0] npc);
        @(negedge clk);
        set_res(br, jmp, pc, tk, tgt, ch, npc);
        @(negedge clk);
        clear_res();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        stall    = 1'b0;
        fetch_pc = 32'd0;
        clear_res();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_pulses("reset", 1'b0, 1'b0, 1'b0);
        check("reset.old_pc", btb_old_pc, 32'd0);
        check("reset.check_addr", btb_check_addr, 32'd0);
        check_gpre("reset.gpre0", 32'h0000_0000, 1'b0);
        check_gpre("reset.gpre1", 32'h1234_5678, 1'b0);
        repeat (8) @(negedge clk);
        check_pulses("reset8", 1'b0, 1'b0, 1'b0);
        check_gpre("reset8.gpre", 32'hFFFF_FFFC, 1'b0);

        // Taken branch predicted not-taken: update plus redirect
        apply_res(1'b1, 1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        check_pulses("t2.n1", 1'b1, 1'b1, 1'b1);
        check("t2.old_pc", btb_old_pc, 32'h100);
        check("t2.check_addr", btb_check_addr, 32'h200);
        check("t2.update_choice", {31'd0, btb_update_choice}, 32'd1);
        check("t2.old_choice", {31'd0, btb_old_choice}, 32'd0);
        check("t2.is_branch", {31'd0, btb_is_branch}, 32'd1);
        check("t2.is_jump", {31'd0, btb_is_jump}, 32'd0);
        @(negedge clk);
        check_pulses("t2.n2", 1'b0, 1'b0, 1'b0);
        check("t2.hold_old_pc", btb_old_pc, 32'h100);

        // Correct not-taken: counter 01->00, then taken brings it only to 01
        do_reset();
        apply_res(1'b1, 1'b0, 32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
        check_pulses("t3.nt", 1'b0, 1'b0, 1'b0);
        apply_res(1'b1, 1'b0, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        check_pulses("t3.tk", 1'b1, 1'b0, 1'b0);
        check_gpre("t3.gpre", 32'h104, 1'b0);

        // Jump with branch flag also set is treated as a jump
        apply_res(1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 32'h600);
        check_pulses("jmp", 1'b1, 1'b0, 1'b0);
        check("jmp.is_jump", {31'd0, btb_is_jump}, 32'd1);
        check("jmp.is_branch", {31'd0, btb_is_branch}, 32'd0);
        check("jmp.check_addr", btb_check_addr, 32'h600);

        // Not-taken with pc+4 wrapping to 0: no mispredict
        apply_res(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b0, 32'h0);
        check_pulses("wrap", 1'b0, 1'b0, 1'b0);
        check("wrap.old_pc", btb_old_pc, 32'hFFFF_FFFC);

        // Not-taken with wrong fall-through: redirect without BTB write
        apply_res(1'b1, 1'b0, 32'h100, 1'b0, 32'h300, 1'b0, 32'h200);
        check_pulses("ntmis", 1'b0, 1'b1, 1'b1);
        check("ntmis.update_choice", {31'd0, btb_update_choice}, 32'd0);

        // Saturation: all updates aimed at index 0x10 by compensating for the GHR
        do_reset();
        apply_res(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        check_gpre("t4.after1", 32'h44, 1'b1);
        apply_res(1'b1, 1'b0, 32'h44, 1'b1, 32'h80, 1'b1, 32'h80);
        apply_res(1'b1, 1'b0, 32'h4C, 1'b1, 32'h80, 1'b1, 32'h80);
        apply_res(1'b1, 1'b0, 32'h5C, 1'b1, 32'h80, 1'b1, 32'h80);
        check_gpre("t4.after4", 32'h7C, 1'b1);
        apply_res(1'b1, 1'b0, 32'h7C, 1'b0, 32'h90, 1'b0, 32'h80);
        check_gpre("t4.dec1", 32'h38, 1'b1);
        apply_res(1'b1, 1'b0, 32'h38, 1'b0, 32'h90, 1'b0, 32'h3C);
        check_gpre("t4.dec2", 32'hB0, 1'b0);

        // Back-to-back mispredicts: the second is wrong-path and dropped
        do_reset();
        @(negedge clk);
        set_res(1'b1, 1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        @(negedge clk);
        check_pulses("t5.n1", 1'b1, 1'b1, 1'b1);
        set_res(1'b1, 1'b0, 32'h300, 1'b1, 32'h400, 1'b0, 32'h304);
        @(negedge clk);
        clear_res();
        check_pulses("t5.n2", 1'b0, 1'b0, 1'b0);
        check("t5.old_pc", btb_old_pc, 32'h100);
        @(negedge clk);
        check_pulses("t5.n3", 1'b0, 1'b0, 1'b0);

        // Stall blocks acceptance
        @(negedge clk);
        stall = 1'b1;
        set_res(1'b1, 1'b0, 32'h700, 1'b1, 32'h800, 1'b0, 32'h704);
        @(negedge clk);
        clear_res();
        stall = 1'b0;
        check_pulses("stall", 1'b0, 1'b0, 1'b0);
        check("stall.old_pc", btb_old_pc, 32'h100);

        // Reset during REMEDY aborts it and restores the PHT
        do_reset();
        apply_res(1'b1, 1'b0, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        check_gpre("t6.trained", 32'h104, 1'b1);
        apply_res(1'b1, 1'b0, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        check_pulses("t6.remedy", 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_pulses("t6.after_rst", 1'b0, 1'b0, 1'b0);
        check("t6.old_pc", btb_old_pc, 32'd0);
        check_gpre("t6.pht_a", 32'h100, 1'b0);
        check_gpre("t6.pht_b", 32'h204, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
